// File: rtl/elevator_call_ctrl.sv
// SCAN-style call scheduler for a 4-floor car: latches call buttons, picks the next target and
// times the door at each stop. Optional build macro ELEV_CALL_REOPEN_EN lets a hall call extend the door.
module elevator_call_ctrl #(
  parameter int unsigned DOOR_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] call,
  input  logic [1:0] floor,
  output logic [1:0] target,
  output logic       stop,
  output logic       door_open,
  output logic [3:0] pending,
  output logic       dir_up
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DOOR = 2'd2
  } state_e;

  localparam logic [7:0] DCNT_LOAD = 8'(DOOR_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] pending_q, pending_d;
  logic       dir_up_q, dir_up_d;
  logic [7:0] dcnt_q, dcnt_d;

  logic [3:0] here_mask, above_mask, below_mask;
  logic [3:0] clr_mask, call_latch;
  logic       here_req, req_above, req_below, req_ahead, reopen;
  logic [1:0] nearest_up, nearest_down;

  for (genvar gi = 0; gi < 4; gi++) begin : g_floor_mask
    assign here_mask[gi]  = (floor == 2'(gi));
    assign above_mask[gi] = (2'(gi) > floor);
    assign below_mask[gi] = (2'(gi) < floor);
  end

  function automatic logic [1:0] lowest_set(input logic [3:0] v);
    lowest_set = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) lowest_set = 2'(i);
    end
  endfunction

  function automatic logic [1:0] highest_set(input logic [3:0] v);
    highest_set = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (v[i]) highest_set = 2'(i);
    end
  endfunction

  assign here_req     = |(pending_q & here_mask);
  assign req_above    = |(pending_q & above_mask);
  assign req_below    = |(pending_q & below_mask);
  assign req_ahead    = dir_up_q ? req_above : req_below;
  assign nearest_up   = lowest_set(pending_q & above_mask);
  assign nearest_down = highest_set(pending_q & below_mask);

  // A call for the floor whose door is already open is never latched.
  assign call_latch = call & ~((state_q == DOOR) ? here_mask : 4'b0000);

`ifdef ELEV_CALL_REOPEN_EN
  assign reopen = |(call & here_mask);
`else
  assign reopen = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    dir_up_d = dir_up_q;
    dcnt_d   = dcnt_q;
    clr_mask = 4'b0000;
    target   = floor;
    case (state_q)
      IDLE: begin
        if (here_req) begin
          clr_mask = here_mask;
          dcnt_d   = DCNT_LOAD;
          state_d  = DOOR;
        end else if (req_above && (dir_up_q || !req_below)) begin
          dir_up_d = 1'b1;
          state_d  = MOVE;
        end else if (req_below) begin
          dir_up_d = 1'b0;
          state_d  = MOVE;
        end
      end
      MOVE: begin
        if (here_req) begin
          clr_mask = here_mask;
          dcnt_d   = DCNT_LOAD;
          state_d  = DOOR;
        end else if (req_ahead) begin
          target = dir_up_q ? nearest_up : nearest_down;
        end else begin
          state_d = IDLE;
        end
      end
      DOOR: begin
        if (reopen) begin
          dcnt_d = DCNT_LOAD;
        end else if (dcnt_q == 8'd0) begin
          state_d = IDLE;
        end else begin
          dcnt_d = dcnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Clearing wins over a same-edge call: that call counts as served.
    pending_d = (pending_q | call_latch) & ~clr_mask;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= 4'b0000;
      dir_up_q  <= 1'b1;
      dcnt_q    <= 8'd0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      dir_up_q  <= dir_up_d;
      dcnt_q    <= dcnt_d;
    end
  end

  assign stop      = (state_q == DOOR);
  assign door_open = (state_q == DOOR);
  assign pending   = pending_q;
  assign dir_up    = dir_up_q;

endmodule

// File: tb/tb_elevator_call_ctrl.sv
// Scoreboard bench for elevator_call_ctrl: a behavioural scheduler model plus a simple car model
// predict outputs each cycle; a negedge monitor pops and compares.
module tb_elevator_call_ctrl;

  localparam int DC = 4;
  localparam int M_IDLE = 0, M_MOVE = 1, M_DOOR = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] call;
  logic [1:0] floor;
  logic [1:0] target;
  logic       stop, door_open, dir_up;
  logic [3:0] pending;

  elevator_call_ctrl #(.DOOR_CYCLES(DC)) dut (
    .clk(clk), .rst(rst), .call(call), .floor(floor),
    .target(target), .stop(stop), .door_open(door_open),
    .pending(pending), .dir_up(dir_up)
  );

  always #5 clk = ~clk;

  typedef struct {
    int target;
    bit stop;
    bit door;
    bit [3:0] pend;
    bit dir;
  } exp_t;

  exp_t exp_q[$];
  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  // Reference: requests as a per-floor array, mode as plain integers.
  bit m_pend[4];
  bit m_dir;
  int m_mode;
  int m_cnt;

  function automatic int model_target(int fl);
    if (m_mode != M_MOVE || m_pend[fl]) return fl;
    if (m_dir) begin
      for (int f = fl + 1; f <= 3; f++) if (m_pend[f]) return f;
    end else begin
      for (int f = fl - 1; f >= 0; f--) if (m_pend[f]) return f;
    end
    return fl;
  endfunction

  function automatic exp_t model_outputs(int fl);
    exp_t e;
    e.target = model_target(fl);
    e.stop   = (m_mode == M_DOOR);
    e.door   = (m_mode == M_DOOR);
    for (int f = 0; f < 4; f++) e.pend[f] = m_pend[f];
    e.dir    = m_dir;
    return e;
  endfunction

  task automatic model_update(input bit [3:0] c, input bit r, input int fl);
    bit clr[4];
    bit any_above, any_below, ahead, reopen;
    if (r) begin
      for (int f = 0; f < 4; f++) m_pend[f] = 1'b0;
      m_dir = 1'b1; m_mode = M_IDLE; m_cnt = 0;
      return;
    end
    any_above = 1'b0; any_below = 1'b0;
    for (int f = 0; f < 4; f++) begin
      clr[f] = 1'b0;
      if (m_pend[f] && f > fl) any_above = 1'b1;
      if (m_pend[f] && f < fl) any_below = 1'b1;
    end
    ahead = m_dir ? any_above : any_below;
`ifdef ELEV_CALL_REOPEN_EN
    reopen = c[fl];
`else
    reopen = 1'b0;
`endif
    if (m_mode == M_DOOR) begin
      c[fl] = 1'b0;
      if (reopen) m_cnt = DC - 1;
      else if (m_cnt == 0) m_mode = M_IDLE;
      else m_cnt = m_cnt - 1;
    end else if (m_pend[fl]) begin
      clr[fl] = 1'b1; m_mode = M_DOOR; m_cnt = DC - 1;
    end else if (m_mode == M_IDLE) begin
      if (any_above && (m_dir || !any_below)) begin m_dir = 1'b1; m_mode = M_MOVE; end
      else if (any_below) begin m_dir = 1'b0; m_mode = M_MOVE; end
    end else if (!ahead) begin
      m_mode = M_IDLE;
    end
    for (int f = 0; f < 4; f++) m_pend[f] = (m_pend[f] | c[f]) & ~clr[f];
  endtask

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got == want) passed++;
    else $display("FAIL cyc=%0d %s: got %0d expected %0d", cyc, name, got, want);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("target", int'(target), e.target);
      check("stop", int'(stop), int'(e.stop));
      check("door_open", int'(door_open), int'(e.door));
      check("pending", int'(pending), int'(e.pend));
      check("dir_up", int'(dir_up), int'(e.dir));
    end
  end

  // One clock: apply inputs, push the prediction, then advance model and car.
  task automatic cycle(input bit [3:0] c, input bit r);
    exp_t e;
    int fl;
    call = c; rst = r;
    fl = int'(floor);
    e = model_outputs(fl);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    model_update(c, r, fl);
    if (!e.stop && e.target != fl) floor = (e.target > fl) ? 2'(fl + 1) : 2'(fl - 1);
  endtask

  function automatic bit model_quiet();
    bit q;
    q = (m_mode == M_IDLE);
    for (int f = 0; f < 4; f++) if (m_pend[f]) q = 1'b0;
    return q;
  endfunction

  task automatic settle(input string name);
    int n;
    n = 0;
    while (!model_quiet() && n < 200) begin
      cycle(4'b0000, 1'b0);
      n++;
    end
    total++;
    if (model_quiet()) passed++;
    else $display("FAIL %s: still busy after %0d cycles, required idle", name, n);
  endtask

  task automatic wait_door_cnt(input int cnt);
    int n;
    n = 0;
    while (!(m_mode == M_DOOR && m_cnt == cnt) && n < 100) begin
      cycle(4'b0000, 1'b0);
      n++;
    end
    total++;
    if (m_mode == M_DOOR && m_cnt == cnt) passed++;
    else $display("FAIL door_wait: door count %0d not reached in %0d cycles", cnt, n);
  endtask

  initial begin
    bit [3:0] c;
    rst = 1'b1; call = 4'b0000; floor = 2'd0;
    model_update(4'b0000, 1'b1, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    cycle(4'b0000, 1'b0);             // reset state
    cycle(4'b0100, 1'b0);             // basic trip to floor 2
    settle("trip_to_2");

    cycle(4'b0001, 1'b0);             // back to floor 0
    settle("back_to_0");
    cycle(4'b1000, 1'b0);             // intermediate pickup at floor 1
    cycle(4'b0010, 1'b0);
    settle("pickup");

    cycle(4'b0001, 1'b0);
    settle("to_0");
    cycle(4'b0100, 1'b0);
    settle("to_2_up");
    cycle(4'b1001, 1'b0);             // serve 3 then reverse to 0
    settle("reverse");

    cycle(4'b0001, 1'b0);             // call at current floor
    settle("same_floor");

    cycle(4'b0010, 1'b0);
    wait_door_cnt(1);
    cycle(4'b0010, 1'b0);             // call at the open-door floor
    settle("door_call");

    cycle(4'b1100, 1'b0);
    cycle(4'b0000, 1'b0);
    cycle(4'b0000, 1'b0);
    cycle(4'b0000, 1'b1);             // reset while moving
    repeat (3) cycle(4'b0000, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      c = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
      cycle(c, ($urandom_range(0, 399) == 0));
    end
    settle("random_drain");

    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL scoreboard: %0d entries left, required 0", exp_q.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/elevator_call_ctrl.md
# elevator_call_ctrl

Call-request controller for the 4-floor elevator car FSM. It latches per-floor call buttons and schedules them SCAN-style: it keeps the current direction while requests remain ahead. It drives the car FSM's `in` (target floor) and `stop` inputs, takes the car's `floor` output as feedback, and runs a door-open timer at each served floor.

## Interface
- `DOOR_CYCLES`, default 4: number of cycles `door_open` stays high per stop; legal range 1..255.
- `clk` input 1: system clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `call` input 4: call buttons, bit i = floor i; level or pulse, sampled every edge.
- `floor` input 2: current floor from the car FSM.
- `target` output 2: requested floor; connects to car FSM `in`.
- `stop` output 1: hold car; connects to car FSM `stop`.
- `door_open` output 1: door open indication.
- `pending` output 4: latched, unserved requests.
- `dir_up` output 1: current scan direction; 1 = up.

## Operation
- Registers:
  - `pending[3:0]`
  - `dir_up`
  - 8-bit door counter `dcnt`
  - state ∈ {IDLE, MOVE, DOOR}
- Reset values: state IDLE, `pending`=0000, `dir_up`=1, `dcnt`=0. Resulting outputs: `stop`=0, `door_open`=0, `target`=`floor`.
- Latching: `pending` |= `call` every edge, except where a clear applies (clear wins, see below).
- IDLE:
  - `target`=`floor`.
  - If `pending[floor]`: go to DOOR, clear that bit.
  - Else if any request is above and (`dir_up` or none below): `dir_up`=1, go to MOVE.
  - Else if any request is below: `dir_up`=0, go to MOVE.
  - Else stay in IDLE.
- MOVE:
  - `target` = `floor` if `pending[floor]`.
  - Otherwise `target` = nearest pending floor strictly beyond `floor` in the direction of `dir_up`.
  - If no such floor exists: `target`=`floor`.
  - If `pending[floor]`: go to DOOR, clear that bit, load `dcnt`=`DOOR_CYCLES-1`.
  - Else if no request ahead: go to IDLE.
- DOOR:
  - `target`=`floor`, `stop`=1, `door_open`=1.
  - `dcnt` decrements each cycle; when `dcnt`==0, go to IDLE.
- Intermediate pickup: a new call at a floor between `floor` and `target` in the travel direction becomes the nearest request. The car stops there first.
- Calls behind the car stay pending until the direction reverses in IDLE.
- Same-edge conflict: `call[f]` asserted on the edge that clears `pending[f]` leaves the bit cleared (request counts as served).
- `stop` = (state==DOOR). `door_open` = (state==DOOR).
- Reset mid-operation returns to IDLE with all requests dropped, regardless of state.

## Timing
- `target`, `stop`, and `door_open` are combinational from registered state plus `floor`. No latency to the car FSM.
- The car moves one floor per edge while `target`≠`floor` and `stop`=0.
- Call latency: call sampled at edge E0 → IDLE decision at E1 → first floor change at E2.
- Arrival: the cycle in which `floor` equals a pending floor keeps `target`=`floor`, so there is no overshoot. DOOR is entered on the next edge.
- Door time: `door_open` is high for exactly `DOOR_CYCLES` cycles, followed by one IDLE cycle before any further motion.

## Configuration
- `ELEV_CALL_REOPEN_EN` defined:
  - In DOOR, `call[floor]` reloads `dcnt`=`DOOR_CYCLES-1`, extending door-open time.
  - The bit is not latched.
- Not defined:
  - In DOOR, `call[floor]` is ignored and not latched.
  - The door closes on schedule.
- In both builds, calls to other floors during DOOR latch normally.

## Test plan
- Reset, pulse `call`=0100 at E0 → `target`=2 from E1+ → `floor` 1 at E2, 2 at E3 → `door_open` high 4 cycles starting after E4 → `pending`=0000, then IDLE.
- At floor 0, `call`=1000, then `call`=0010 while `floor`=0 → stops at floor 1 first (door 4 cycles) → then floor 3 → `pending`=0000.
- At floor 2 with `dir_up`=1, `call`=1001 together → serves 3 first, then reverses: `dir_up`=0, serves 0.
- `call`=0001 at floor 0 in IDLE → DOOR next edge, `floor` stays 0, `stop`=1 for 4 cycles.
- During DOOR at floor 1 with 2 cycles remaining, pulse `call`=0010:
  - With `ELEV_CALL_REOPEN_EN` → `door_open` lasts 4 more cycles.
  - Without → closes after 2; `pending`=0000.
- `rst` asserted in MOVE with `pending`=1100 → next cycle IDLE, `pending`=0000, `stop`=0, `dir_up`=1.
